// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension multiply/divide unit: funct3 ops,
// FSM states and the supported multiplier latency range.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam int unsigned MUL_LATENCY_MIN = 1;
  localparam int unsigned MUL_LATENCY_MAX = 4;

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient
// bit per cycle; i_early stops after a single step (result supplied by caller).
module muldiv_div_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic                  i_early,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [DATA_WIDTH-1:0] r_div;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_early;

  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_diff;

  // Dividend bits shift out of r_quot's top while quotient bits shift in below.
  assign w_shift = {r_rem, r_quot[DATA_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_early <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem   <= '0;
      r_quot  <= i_dividend;
      r_div   <= i_divisor;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_early <= i_early;
    end else if (r_busy) begin
      if (!w_diff[DATA_WIDTH]) begin
        r_rem  <= w_diff[DATA_WIDTH-1:0];
        r_quot <= {r_quot[DATA_WIDTH-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift[DATA_WIDTH-1:0];
        r_quot <= {r_quot[DATA_WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
      if (r_early || r_cnt == CW'(DATA_WIDTH - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit with valid/ready handshake.
// Optional macro MULDIV_DIV_EARLY_EXIT_EN: trivial divides finish after one step.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [2:0]            funct3,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned LAT = (MUL_LATENCY < MUL_LATENCY_MIN) ? MUL_LATENCY_MIN :
                                (MUL_LATENCY > MUL_LATENCY_MAX) ? MUL_LATENCY_MAX : MUL_LATENCY;

  state_e         r_state;
  logic [W-1:0]   r_op1, r_op2, r_result;
  logic [2:0]     r_mul_cnt;
  logic           r_a_sgn, r_b_sgn, r_sel, r_neg_q, r_neg_r;

  funct3_e        w_f3;
  logic           w_accept, w_div_sgn, w_a_neg, w_b_zero, w_early;
  logic [W-1:0]   w_mag_a, w_mag_b, w_div_quot, w_div_rem, w_div_res;
  logic           w_div_done;
  logic [2*W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [W-1:0]   w_mul_res;

  assign w_f3      = funct3_e'(funct3);
  assign w_accept  = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_div_sgn = (w_f3 == F3_DIV) || (w_f3 == F3_REM);
  assign w_a_neg   = w_div_sgn && op1[W-1];
  assign w_mag_a   = w_a_neg ? -op1 : op1;
  assign w_mag_b   = (w_div_sgn && op2[W-1]) ? -op2 : op2;
  assign w_b_zero  = (op2 == '0);

`ifdef MULDIV_DIV_EARLY_EXIT_EN
  logic         w_ovf, r_ovf, r_b_zero, r_early;
  logic [W-1:0] w_early_res;
  assign w_ovf   = w_div_sgn && (op1 == {1'b1, {(W-1){1'b0}}}) && (op2 == '1);
  assign w_early = w_b_zero || w_ovf || (w_mag_a < w_mag_b);
  // Remainder is op1 unless overflow; quotient is all-ones, op1 or zero.
  assign w_early_res = r_sel ? (r_ovf ? '0 : r_op1)
                             : (r_b_zero ? '1 : (r_ovf ? r_op1 : '0));
`else
  assign w_early = 1'b0;
`endif

  assign w_a_ext   = {{W{r_a_sgn && r_op1[W-1]}}, r_op1};
  assign w_b_ext   = {{W{r_b_sgn && r_op2[W-1]}}, r_op2};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = r_sel ? w_prod[2*W-1:W] : w_prod[W-1:0];

  assign w_div_res = r_sel ? (r_neg_r ? -w_div_rem : w_div_rem)
                           : (r_neg_q ? -w_div_quot : w_div_quot);

  muldiv_div_core #(.DATA_WIDTH(W)) u_div_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept && funct3[2]),
    .i_flush    (flush),
    .i_early    (w_early),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op1     <= '0;
      r_op2     <= '0;
      r_result  <= '0;
      r_mul_cnt <= '0;
      r_a_sgn   <= 1'b0;
      r_b_sgn   <= 1'b0;
      r_sel     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
      r_ovf     <= 1'b0;
      r_b_zero  <= 1'b0;
      r_early   <= 1'b0;
`endif
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op1     <= op1;
          r_op2     <= op2;
          r_mul_cnt <= 3'd1;
          r_a_sgn   <= (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU);
          r_b_sgn   <= (w_f3 == F3_MULH);
          r_sel     <= funct3[2] ? funct3[1] : (w_f3 != F3_MUL);
          r_neg_q   <= w_div_sgn && (op1[W-1] ^ op2[W-1]) && !w_b_zero;
          r_neg_r   <= w_a_neg;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
          r_ovf     <= w_ovf;
          r_b_zero  <= w_b_zero;
          r_early   <= w_early;
`endif
          r_state   <= funct3[2] ? ST_DIV : ST_MUL;
        end
        ST_MUL: begin
          if (r_mul_cnt == 3'(LAT)) begin
            r_result <= w_mul_res;
            r_state  <= ST_DONE;
          end else begin
            r_mul_cnt <= r_mul_cnt + 3'd1;
          end
        end
        ST_DIV: if (w_div_done) begin
`ifdef MULDIV_DIV_EARLY_EXIT_EN
          if (r_early) begin
            r_result <= w_early_res;
            r_state  <= ST_DONE;
          end else begin
            r_state <= ST_FIX;
          end
`else
          r_state <= ST_FIX;
`endif
        end
        ST_FIX: begin
          r_result <= w_div_res;
          r_state  <= ST_DONE;
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [2:0]  funct3 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.DATA_WIDTH(32), .MUL_LATENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] ma, mb;
    if (!f3[2]) return 2;
    sgn = !f3[0];
    ma = (sgn && a[31]) ? 32'(0 - a) : a;
    mb = (sgn && b[31]) ? 32'(0 - b) : b;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
    if (b == 32'h0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) || ma < mb) return 2;
`else
    if (ma > mb) return 34;
`endif
    return 34;
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat;
    string       id;
    exp = model(f3, a, b);
    id  = $sformatf("f3=%0d a=%h b=%h", f3, a, b);
    @(negedge clk);
    check({id, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op1 = a; op2 = b; funct3 = f3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({id, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({id, " latency"}, 32'(lat), 32'(exp_latency(f3, a, b)));
    check({id, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({id, " hold valid"}, 32'(out_valid), 32'd1);
      check({id, " hold result"}, result, exp);
      check({id, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({id, " post in_ready"}, 32'(in_ready), 32'd1);
    check({id, " post valid"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", 32'(in_ready), 32'd1);

    do_op(F3_MULH,   32'h80000000, 32'h80000000, 0);
    do_op(F3_MULHU,  32'h80000000, 32'h80000000, 0);
    do_op(F3_MUL,    32'h80000000, 32'h80000000, 0);
    do_op(F3_DIV,    32'hFFFFFFF9, 32'h2, 0);
    do_op(F3_REM,    32'hFFFFFFF9, 32'h2, 0);
    do_op(F3_DIVU,   32'h5, 32'h0, 0);
    do_op(F3_REMU,   32'h5, 32'h0, 0);
    do_op(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 0);
    do_op(F3_REM,    32'h80000000, 32'hFFFFFFFF, 0);
    do_op(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);

    // Flush mid-divide while a new request is offered.
    @(negedge clk);
    in_valid = 1'b1; op1 = 32'd100; op2 = 32'd7; funct3 = F3_DIVU;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op1 = 32'd9; op2 = 32'd9; funct3 = F3_MUL;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush no result", 32'(seen), 32'd0);
    do_op(F3_MUL, 32'd3, 32'd4, 0);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    in_valid = 1'b1; op1 = 32'hFFFF0000; op2 = 32'd3; funct3 = F3_DIV;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst release in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("rst no result", 32'(seen), 32'd0);
    do_op(F3_DIVU, 32'd100, 32'd7, 0);
    do_op(F3_REMU, 32'd100, 32'd7, 0);

    for (int n = 0; n < 48; n++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
